logic_gate_fifo: RTL
====================

// Module: logic_gate_fifo
// PURPOSE
//  Parametrised bitwise logic unit: applies one of eight 2-input gate functions
//  (AND/OR/NAND/NOR/XOR/XNOR/NOT/BUF) to WIDTH-bit operands.
//  Results are buffered in a DEPTH-entry output FIFO with valid/ready on both sides.
//  Successor to the single-bit combinational gate cells; it is the gate stage in
//  streaming datapaths where the consumer may stall.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=1)
//  DEPTH  4  output FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept (FIFO not full)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (ignored for NOT/BUF)
//  op         in   3      0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 NOT a,7 BUF a
//  out_valid  out  1      FIFO head valid (not empty)
//  out_ready  in   1      consumer takes head
//  y          out  WIDTH  result at FIFO head
//  y_par      out  1      XOR-reduction of y (see CONFIGURATION)
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (async, rst=1): rd/wr pointers=0, count=0, out_valid=0, in_ready=1,
//    every FIFO entry=0, so y=0 and y_par=0. Outputs stay at reset values while rst=1.
//  - push = in_valid & in_ready; pop = out_valid & out_ready (both sampled at posedge clk).
//  - On push: f(a,b,op) is computed combinationally and written to mem[wr_ptr] in the
//    same edge; wr_ptr advances with wrap DEPTH-1 -> 0.
//  - Latency: an accepted result is visible on y with out_valid=1 one cycle after the
//    accepting edge when the FIFO was empty. Otherwise it appears when it reaches the head.
//  - On pop: rd_ptr advances with wrap. y always shows mem[rd_ptr]. y holds stale data when empty.
//  - in_ready = (count != DEPTH), derived from registered state only.
//    A full FIFO rejects push even if a pop occurs in the same cycle.
//  - out_valid = (count != 0). Pop is ignored when empty.
//  - Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
//  - Count updates: push only +1, pop only -1, otherwise hold. Never exceeds DEPTH or goes below 0.
//  - Data, op and b are don't-care when push=0. No X may propagate into mem without push.
//  - Reset mid-stream discards all entries. The first push after reset lands in mem[0].
//  - All op codes are legal. There is no error output.
// CONFIGURATION
//  - LGU_PARITY_EN defined: each entry stores an extra bit = ^f(a,b,op) at push.
//    y_par outputs the stored bit of the head entry (reset value 0).
//  - LGU_PARITY_EN undefined: no parity storage; y_par tied to 1'b0.
//  - The port list is identical in both builds.
// TESTING  (WIDTH=8, DEPTH=4)
//  1. Reset: rst=1 mid-stream with 3 entries -> immediately out_valid=0, count=0, y=8'h00,
//     in_ready=1 (no clk edge needed).
//  2. All ops with a=8'hC5, b=8'h3A, out_ready=1 -> y sequence:
//     00, FF, FF, 00, FF, 00, 3A, C5, each 1 cycle after push.
//  3. Fill: 4 pushes (NOR, a=00, b=0F) with out_ready=0 -> count=4, in_ready=0.
//     A 5th push is rejected. Then 4 pops -> y=F0 x4, count=0.
//  4. Full + simultaneous in_valid/out_ready: pop occurs, push blocked that cycle,
//     accepted on the next cycle. Count goes 4->3->4.
//  5. Wrap: 10 push/pop pairs at throughput 1 with XOR of a=i, b=8'hFF ->
//     y = ~i in order, count stays 1, no loss or duplication.
//  6. LGU_PARITY_EN: AND a=8'h07, b=8'h03 -> y=03, y_par=0; OR a=01, b=00 -> y_par=1.
//     Without the macro, y_par=0 always.

Source files
------------

// File: rtl/logic_gate_fifo.sv
// logic_gate_fifo: applies one of eight bitwise gate functions to WIDTH-bit operands
// and queues each result in a DEPTH-entry output FIFO.
// Latency: a result reaches y one cycle after the accepting edge if the FIFO was empty.
// Backpressure: in_ready drops when the FIFO is full. A pop in that same cycle does not
// reopen the input until the next cycle.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b, op are sampled on push
//   op                   0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
//   out_valid/out_ready  result handshake; y always shows the head entry
//   y_par                stored XOR-reduction of the head entry when LGU_PARITY_EN is defined,
//                        otherwise tied to 0
//   count                current occupancy, 0..DEPTH
// Build option: define LGU_PARITY_EN to store a parity bit alongside each entry.
module logic_gate_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [2:0]               op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         y,
   output logic                     y_par,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] f_res;
   logic             push;
   logic             pop;

   // The handshake outputs depend only on registered occupancy, never on this cycle's inputs.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign y         = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      f_res = '0;
      unique case (op)
         3'd0: f_res = a & b;
         3'd1: f_res = a | b;
         3'd2: f_res = ~(a & b);
         3'd3: f_res = ~(a | b);
         3'd4: f_res = a ^ b;
         3'd5: f_res = ~(a ^ b);
         3'd6: f_res = ~a;
         3'd7: f_res = a;
         default: f_res = '0;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Memory is written only on push, so X on idle inputs never reaches the storage.
      if (push) begin
         mem_d[wr_ptr_q] = f_res;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

`ifdef LGU_PARITY_EN
   logic par_q [DEPTH];
   logic par_d [DEPTH];

   always_comb begin
      par_d = par_q;
      if (push) begin
         par_d[wr_ptr_q] = ^f_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            par_q[i] <= 1'b0;
         end
      end else begin
         par_q <= par_d;
      end
   end

   assign y_par = par_q[rd_ptr_q];
`else
   assign y_par = 1'b0;
`endif

endmodule
